// File: rtl/mac_stop_ctrl.sv
// Sequencer for C = A x B over three single-port SRAM slices.
// Walks C row-major, K paired A/B reads per element, then one C write.
module mac_stop_ctrl #(
    parameter int M                        = 3,
    parameter int K                        = 5,
    parameter int N                        = 5,
    parameter int DATA_WIDTH_INIT_MATRIX   = 32,
    parameter int DATA_WIDTH_RESULT_MATRIX = 2 * DATA_WIDTH_INIT_MATRIX + $clog2(K)
) (
    input  logic                                clk,
    input  logic                                resetn,
    input  logic                                start,
    input  logic                                abort,
    output logic                                busy,
    output logic                                done,
    output logic [$clog2(M)-1:0]                row_addr_a,
    output logic [$clog2(K)-1:0]                col_addr_a,
    output logic [$clog2(K)-1:0]                row_addr_b,
    output logic [$clog2(N)-1:0]                col_addr_b,
    output logic [$clog2(M)-1:0]                row_addr_c,
    output logic [$clog2(N)-1:0]                col_addr_c,
    output logic                                matrix_a_re,
    output logic                                matrix_b_re,
    output logic                                matrix_c_we,
    output logic [DATA_WIDTH_RESULT_MATRIX-1:0] data_in_c,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_a,
    input  logic [DATA_WIDTH_INIT_MATRIX-1:0]   data_out_b
);

    localparam int W  = DATA_WIDTH_INIT_MATRIX;
    localparam int R  = DATA_WIDTH_RESULT_MATRIX;
    localparam int MW = $clog2(M);
    localparam int KW = $clog2(K);
    localparam int NW = $clog2(N);

    typedef enum logic [1:0] {IDLE, FETCH, WRITE, DONE} state_t;

    state_t          state, state_n;
    logic [MW-1:0]   i, i_n;
    logic [KW-1:0]   k, k_n;
    logic [NW-1:0]   j, j_n;
    logic [R-1:0]    acc;
    logic [2*W-1:0]  prod;
    logic [R-1:0]    sum;
    logic            last_i, last_j, last_k;

    // prod is the operand pair read in the previous cycle
    assign prod   = data_out_a * data_out_b;
    assign sum    = acc + R'(prod);
    assign last_i = (i == MW'(M - 1));
    assign last_j = (j == NW'(N - 1));
    assign last_k = (k == KW'(K - 1));

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            i     <= '0;
            j     <= '0;
            k     <= '0;
        end else begin
            state <= state_n;
            i     <= i_n;
            j     <= j_n;
            k     <= k_n;
        end
    end

    // k==1 means the returning product is the first of a new element
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            acc <= '0;
        else if (state == FETCH && k != '0)
            acc <= (k == KW'(1)) ? R'(prod) : sum;
    end

    always_comb begin
        state_n     = state;
        i_n         = i;
        j_n         = j;
        k_n         = k;
        busy        = 1'b0;
        done        = 1'b0;
        row_addr_a  = '0;
        col_addr_a  = '0;
        row_addr_b  = '0;
        col_addr_b  = '0;
        row_addr_c  = '0;
        col_addr_c  = '0;
        matrix_a_re = 1'b0;
        matrix_b_re = 1'b0;
        matrix_c_we = 1'b0;
        data_in_c   = '0;

        case (state)
            IDLE: begin
                if (start && !abort) begin
                    state_n = FETCH;
                    i_n     = '0;
                    j_n     = '0;
                    k_n     = '0;
                end
            end
            FETCH: begin
                busy        = 1'b1;
                matrix_a_re = 1'b1;
                matrix_b_re = 1'b1;
                row_addr_a  = i;
                col_addr_a  = k;
                row_addr_b  = k;
                col_addr_b  = j;
                if (last_k)
                    state_n = WRITE;
                else
                    k_n = k + 1'b1;
            end
            WRITE: begin
                busy        = 1'b1;
                matrix_c_we = !abort;
                row_addr_c  = i;
                col_addr_c  = j;
                data_in_c   = sum;
                k_n         = '0;
                state_n     = FETCH;
                if (last_j) begin
                    j_n = '0;
                    if (last_i) begin
                        i_n     = '0;
                        state_n = DONE;
                    end else begin
                        i_n = i + 1'b1;
                    end
                end else begin
                    j_n = j + 1'b1;
                end
            end
            DONE: begin
                busy    = 1'b1;
                done    = !abort;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        // abort overrides every transition out of a busy state
        if (abort && state != IDLE) begin
            state_n = IDLE;
            i_n     = '0;
            j_n     = '0;
            k_n     = '0;
        end
    end

endmodule

// File: tb/tb_mac_stop_ctrl.sv
// Scoreboard bench for mac_stop_ctrl: SRAM model, reference C, write/done/busy monitor.
module tb_mac_stop_ctrl;

    localparam int M  = 3;
    localparam int K  = 5;
    localparam int N  = 5;
    localparam int W  = 32;
    localparam int R  = 2 * W + $clog2(K);
    localparam int RUN = M * N * (K + 1);

    typedef struct {
        int           i;
        int           j;
        logic [R-1:0] d;
    } wr_t;

    logic                 clk = 1'b0;
    logic                 resetn = 1'b0;
    logic                 start = 1'b0;
    logic                 abort = 1'b0;
    logic                 busy, done;
    logic [$clog2(M)-1:0] row_addr_a, row_addr_c;
    logic [$clog2(K)-1:0] col_addr_a, row_addr_b;
    logic [$clog2(N)-1:0] col_addr_b, col_addr_c;
    logic                 matrix_a_re, matrix_b_re, matrix_c_we;
    logic [R-1:0]         data_in_c;
    logic [W-1:0]         data_out_a, data_out_b;

    logic [W-1:0] ma [M][K];
    logic [W-1:0] mb [K][N];
    logic [R-1:0] expc [M][N];

    wr_t exp_q[$];
    int  exp_done[$];
    int  exp_busy[$];
    int  cyc = 0;
    int  blen = 0;
    int  n_cmp = 0;
    int  n_err = 0;

    int da [M][K] = '{'{4,3,5,4,4}, '{3,4,4,5,4}, '{5,4,3,4,4}};
    int db [K][N] = '{'{5,6,5,5,6}, '{6,5,6,6,5}, '{5,5,6,5,6}, '{6,6,5,6,5}, '{5,5,6,5,5}};
    int dc [M][N] = '{'{107,108,112,107,109}, '{109,108,112,109,107}, '{108,109,111,108,108}};

    mac_stop_ctrl #(.M(M), .K(K), .N(N), .DATA_WIDTH_INIT_MATRIX(W)) dut (
        .clk(clk), .resetn(resetn), .start(start), .abort(abort),
        .busy(busy), .done(done),
        .row_addr_a(row_addr_a), .col_addr_a(col_addr_a),
        .row_addr_b(row_addr_b), .col_addr_b(col_addr_b),
        .row_addr_c(row_addr_c), .col_addr_c(col_addr_c),
        .matrix_a_re(matrix_a_re), .matrix_b_re(matrix_b_re),
        .matrix_c_we(matrix_c_we), .data_in_c(data_in_c),
        .data_out_a(data_out_a), .data_out_b(data_out_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // SRAM slices: read data one cycle after the enable
    always @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            data_out_a <= '0;
            data_out_b <= '0;
        end else begin
            if (matrix_a_re) data_out_a <= ma[row_addr_a][col_addr_a];
            if (matrix_b_re) data_out_b <= mb[row_addr_b][col_addr_b];
        end
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] want);
        n_cmp++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
        end
    endtask

    // Monitor: consumes expected writes, done cycles and busy lengths
    always @(negedge clk) begin
        if (!resetn) begin
            blen = 0;
        end else begin
            if (matrix_c_we) begin
                if (exp_q.size() == 0) begin
                    check("c_write_unexpected", {row_addr_c, col_addr_c}, 128'hDEAD);
                end else begin
                    wr_t e;
                    e = exp_q.pop_front();
                    check("c_write_addr", {row_addr_c, col_addr_c},
                          {e.i[$clog2(M)-1:0], e.j[$clog2(N)-1:0]});
                    check("c_write_data", data_in_c, e.d);
                end
            end
            if (done) begin
                if (exp_done.size() == 0) check("done_unexpected", cyc, -1);
                else check("done_cycle", cyc, exp_done.pop_front());
            end
            if (busy) begin
                blen++;
            end else begin
                if (blen > 0) begin
                    if (exp_busy.size() == 0) check("busy_unexpected", blen, 0);
                    else check("busy_len", blen, exp_busy.pop_front());
                end
                blen = 0;
                check("idle_quiet", {matrix_a_re, matrix_b_re, matrix_c_we, done,
                                     |row_addr_a, |col_addr_a, |row_addr_b, |col_addr_b,
                                     |row_addr_c, |col_addr_c, |data_in_c}, 0);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode 0: full-range random, 1: small random, 2: all ones, 3: directed table
    task automatic fill(input int mode);
        for (int i = 0; i < M; i++)
            for (int k = 0; k < K; k++)
                case (mode)
                    0: ma[i][k] = $urandom;
                    1: ma[i][k] = W'($urandom_range(0, 15));
                    2: ma[i][k] = '1;
                    default: ma[i][k] = W'(da[i][k]);
                endcase
        for (int k = 0; k < K; k++)
            for (int j = 0; j < N; j++)
                case (mode)
                    0: mb[k][j] = $urandom;
                    1: mb[k][j] = W'($urandom_range(0, 15));
                    2: mb[k][j] = '1;
                    default: mb[k][j] = W'(db[k][j]);
                endcase
        for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++) begin
                logic [R-1:0] s;
                s = '0;
                for (int k = 0; k < K; k++) s = s + R'(ma[i][k]) * R'(mb[k][j]);
                expc[i][j] = (mode == 3) ? R'(dc[i][j]) : s;
            end
    endtask

    // Expected activity of one run launched at t0, optionally aborted in cycle ab
    task automatic push_run(input int t0, input int ab);
        for (int e = 0; e < M * N; e++) begin
            wr_t w;
            if (ab >= 0 && t0 + e * (K + 1) + K >= ab) break;
            w.i = e / N;
            w.j = e % N;
            w.d = expc[w.i][w.j];
            exp_q.push_back(w);
        end
        if (ab < 0) begin
            exp_done.push_back(t0 + RUN);
            exp_busy.push_back(RUN + 1);
        end else begin
            exp_busy.push_back(ab - t0 + 1);
        end
    endtask

    task automatic wait_idle(input int budget);
        for (int c = 0; c < budget; c++) begin
            step();
            if (exp_q.size() == 0 && exp_done.size() == 0 && exp_busy.size() == 0 && !busy)
                return;
        end
        check("timeout_pending", exp_q.size() + exp_done.size() + exp_busy.size(), 0);
        exp_q.delete();
        exp_done.delete();
        exp_busy.delete();
    endtask

    // ab_off < 0: full run; else abort in cycle t0+ab_off
    task automatic run(input int ab_off);
        int t0, ab;
        start = 1'b1;
        t0 = cyc + 1;
        ab = (ab_off < 0) ? -1 : t0 + ab_off;
        push_run(t0, ab);
        step();
        start = 1'b0;
        if (ab >= 0) begin
            while (cyc < ab) step();
            abort = 1'b1;
            step();
            abort = 1'b0;
        end
        wait_idle(RUN + 20);
    endtask

    initial begin
        repeat (3) step();
        check("reset_outputs", {busy, done, matrix_a_re, matrix_b_re, matrix_c_we,
                                |row_addr_a, |col_addr_c, |data_in_c}, 0);
        resetn = 1'b1;
        step();
        check("idle_after_release", busy, 0);

        fill(3);
        run(-1);

        fill(2);
        run(-1);

        // start and abort together in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        step();
        start = 1'b0;
        abort = 1'b0;
        step();
        check("start_abort_idle", busy, 0);

        // abort in the 3rd FETCH of element (0,1), then a clean rerun
        fill(1);
        run(K + 1 + 2);
        check("idle_after_abort", busy, 0);
        run(-1);

        // asynchronous reset in the middle of the first WRITE
        fill(0);
        begin
            int t0;
            start = 1'b1;
            t0 = cyc + 1;
            push_run(t0, -1);
            step();
            start = 1'b0;
            while (cyc < t0 + K) step();
            #1 resetn = 1'b0;
            #1;
            check("rst_midwrite", {matrix_c_we, busy, |row_addr_c, |col_addr_c,
                                   |row_addr_a, matrix_a_re, |data_in_c}, 0);
            exp_q.delete();
            exp_done.delete();
            exp_busy.delete();
            step();
            step();
            resetn = 1'b1;
            step();
        end
        run(-1);

        // start held across a whole run: one immediate restart only
        fill(1);
        begin
            int t0, t1;
            start = 1'b1;
            t0 = cyc + 1;
            t1 = t0 + RUN + 2;
            push_run(t0, -1);
            push_run(t1, -1);
            while (cyc < t1) step();
            start = 1'b0;
            wait_idle(RUN + 20);
        end

        for (int r = 0; r < 6; r++) begin
            fill(r % 2);
            if (r % 2 == 1) run($urandom_range(0, RUN));
            else run(-1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mac_stop_ctrl.md
# mac_stop_ctrl

Sequencing controller for the `mac_stop_mem` matrix store: on a start pulse it walks C = A × B element by element. For each element it issues paired reads of SRAM A and SRAM B, multiply-accumulates the returned operands, and writes the finished sum into SRAM C. It sits between the host/top level (start/abort/busy/done) and the three memory slices, and owns every address, read-enable and C-write port of the store while busy.

## Interface
- `M`, 3, rows of A and C (≥2)
- `K`, 5, columns of A / rows of B (≥2)
- `N`, 5, columns of B and C (≥2)
- `DATA_WIDTH_INIT_MATRIX`, 32, A/B element width W
- `DATA_WIDTH_RESULT_MATRIX`, 2·W+$clog2(K), C element width R (derived, not overridden)

Ports:
- `clk`  in  1  single clock, all state on rising edge
- `resetn`  in  1  asynchronous, active-low reset
- `start`  in  1  begin a multiply; sampled only in IDLE
- `abort`  in  1  synchronous cancel; returns to IDLE, no done
- `busy`  out  1  high from first FETCH cycle through DONE
- `done`  out  1  one-cycle pulse after the last C write
- `row_addr_a`  out  $clog2(M)  A row (i)
- `col_addr_a`  out  $clog2(K)  A column (k)
- `row_addr_b`  out  $clog2(K)  B row (k)
- `col_addr_b`  out  $clog2(N)  B column (j)
- `row_addr_c`, `col_addr_c`  out  $clog2(M) / $clog2(N)  C write address (i, j)
- `matrix_a_re`, `matrix_b_re`  out  1  read enables, always asserted together
- `matrix_c_we`  out  1  C write enable
- `data_in_c`  out  R  C write data
- `data_out_a`, `data_out_b`  in  W  read data, valid one cycle after re

## Operation
- States: IDLE, FETCH, WRITE, DONE. Counters i (0..M-1), j (0..N-1), k (0..K-1), accumulator `acc` (R bits).
- IDLE: outputs quiescent. `start`=1 → FETCH with i=j=k=0.
- FETCH (K cycles per element): drive A(i,k), B(k,j), re=1. The cycle after a read, product p = data_out_a·data_out_b (unsigned, 2W bits) is added: `acc <= (k_prev==0 ? 0 : acc) + p`. After k=K-1 → WRITE.
- WRITE (1 cycle): re=0, `matrix_c_we`=1, C address (i,j), `data_in_c` = acc + p(k=K-1) combinationally. Advance j; on j wrap advance i; k=0. If (i,j) was (M-1,N-1) → DONE, else → FETCH.
- DONE (1 cycle): `done`=1, `busy`=1 → IDLE.
- Order: row-major over C (j fastest), k ascending within each element.
- Arithmetic: unsigned, zero-extended to R. No overflow, because K·(2^W−1)² < 2^R.
- Outside FETCH/WRITE, all addresses, re, we and `data_in_c` are 0.
- `start` while busy is ignored. `start` and `abort` together in IDLE: abort wins, and the block stays in IDLE.
- `abort` in FETCH/WRITE/DONE → IDLE next cycle. The C write in the abort cycle is suppressed (we forced 0), `done` stays 0, and already-written C entries are kept.

## Timing
- Reset (async, resetn=0): state IDLE, all counters/acc 0, every output 0, including a reset asserted mid-operation. Release takes effect on the next rising edge.
- `start` sampled at edge t0 → first FETCH at cycle t0+1.
- Per element K+1 cycles. `done` is high in cycle t0+1+M·N·(K+1). `busy` falls the following cycle.
- The read issued in cycle c returns in c+1. The accumulate for read c is registered at the end of c+1, so back-to-back FETCH has no bubbles.
- After DONE returns to IDLE, a new `start` can be accepted the next cycle.

## Test plan
- 2×2×2, A={{4,3},{2,1}}, B={{8,7},{6,5}} preloaded, start pulse → C writes (0,0)=50, (0,1)=43, (1,0)=22, (1,1)=19 in that order. `done` is 13 cycles after the start edge, and `busy` is high for exactly 13 cycles.
- 3×5×5, A={{4,3,5,4,4},{3,4,4,5,4},{5,4,3,4,4}}, B={{5,6,5,5,6},{6,5,6,6,5},{5,5,6,5,6},{6,6,5,6,5},{5,5,6,5,5}} → C row0 = 107,108,112,107,109; row1 = 109,108,112,109,107; row2 = 108,109,111,108,108. `done` at cycle 91.
- Width corner: W=32, K=4, all A=B=0xFFFFFFFF → every C = 4·(2^32−1)² exactly, with no truncation in the 66-bit result.
- Abort in the 3rd FETCH of element (0,1) → no write to (0,1), `done` never pulses, IDLE next cycle. A fresh start then recomputes all of C correctly.
- resetn dropped mid-WRITE → `matrix_c_we`, addresses and `busy` go to 0 immediately (asynchronously). Start after release produces the correct C.
- `start` held high through a whole run → exactly one run plus one immediate restart after DONE, and no re-trigger while busy.
